// File: rtl/mem_bus_if_if.sv
// Data-bus bundle between the mem_bus_if master and the data-memory slave.
// The master drives address, write data and strobes; the slave returns rdata/ack.
interface mem_bus_if_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic              bus_rd;
    logic              bus_wr;
    logic [DATA_W-1:0] bus_rdata;
    logic              bus_ack;

    modport master (
        output bus_addr,
        output bus_wdata,
        output bus_rd,
        output bus_wr,
        input  bus_rdata,
        input  bus_ack
    );

    modport slave (
        input  bus_addr,
        input  bus_wdata,
        input  bus_rd,
        input  bus_wr,
        output bus_rdata,
        output bus_ack
    );
endinterface

// File: rtl/mem_bus_if.sv
// mem_bus_if: registered strobe/acknowledge data-bus master for the MiniRISC datapath.
// Define MEM_BUS_TIMEOUT_EN to abort transfers that wait TIMEOUT cycles without ack.
module mem_bus_if #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_rd,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              stall,
    output logic              bus_err,
    mem_bus_if_if.master      bus
);

    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("mem_bus_if: TIMEOUT must lie in 1..255");
    end

`ifdef MEM_BUS_TIMEOUT_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2,
        ERR    = 2'd3
    } state_t;

    localparam logic [7:0] TMO = 8'(TIMEOUT);

    logic [7:0] cnt_q, cnt_d, cnt_inc;
    logic       err_q, err_d;
`else
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;
`endif

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
`ifdef MEM_BUS_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
`endif
        case (state_q)
            IDLE: begin
                if (req_wr || req_rd) begin
                    addr_d  = cpu_addr;
                    wdata_d = cpu_wdata;
                    wr_d    = req_wr;
                    rd_d    = req_rd & ~req_wr;
                    state_d = ACCESS;
`ifdef MEM_BUS_TIMEOUT_EN
                    cnt_d   = 8'd0;
`endif
                end
            end
            ACCESS: begin
                // An ack always wins over a timeout firing in the same cycle.
                if (bus.bus_ack) begin
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    state_d = DONE;
                    if (rd_q) begin
                        rdata_d = bus.bus_rdata;
                    end
                end
`ifdef MEM_BUS_TIMEOUT_EN
                else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == TMO) begin
                        rd_d    = 1'b0;
                        wr_d    = 1'b0;
                        err_d   = 1'b1;
                        state_d = ERR;
                        if (rd_q) begin
                            rdata_d = '1;
                        end
                    end
                end
`endif
            end
            DONE: begin
                state_d = IDLE;
            end
`ifdef MEM_BUS_TIMEOUT_EN
            ERR: begin
                state_d = IDLE;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
`ifdef MEM_BUS_TIMEOUT_EN
            cnt_q   <= 8'd0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
`ifdef MEM_BUS_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    // Gating with rst keeps stall low while reset is held, even with a request pending.
    assign stall = rst & (((state_q == IDLE) & (req_rd | req_wr)) | (state_q == ACCESS));

    assign cpu_rdata     = rdata_q;
    assign bus.bus_addr  = addr_q;
    assign bus.bus_wdata = wdata_q;
    assign bus.bus_rd    = rd_q;
    assign bus.bus_wr    = wr_q;

`ifdef MEM_BUS_TIMEOUT_EN
    assign bus_err = err_q;
`else
    assign bus_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_if.sv
// Directed bench for mem_bus_if: reset, read/write timing, priority, timeout, reset abort, back-to-back.
module tb_mem_bus_if;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req_rd = 1'b0;
    logic       req_wr = 1'b0;
    logic [7:0] cpu_addr = 8'h00;
    logic [7:0] cpu_wdata = 8'h00;
    logic [7:0] cpu_rdata;
    logic       stall;
    logic       bus_err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    mem_bus_if_if #(.ADDR_W(8), .DATA_W(8)) bus_i ();

    mem_bus_if #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(15)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_rd    (req_rd),
        .req_wr    (req_wr),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .stall     (stall),
        .bus_err   (bus_err),
        .bus       (bus_i)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // Runs one transfer: request driven at cycle 0, ack in cycle waits+1; stops when stall drops.
    task automatic do_xfer(input logic is_rd, input logic is_wr, input logic [7:0] addr,
                           input logic [7:0] wdata, input int waits, input logic [7:0] rdata,
                           output int n_stall, output int n_rd, output int n_wr, output int n_err,
                           output logic held, output int first_cyc, output logic ended);
        n_stall = 0; n_rd = 0; n_wr = 0; n_err = 0;
        held = 1'b1; first_cyc = -1; ended = 1'b0;
        for (int c = 0; c < 300 && !ended; c++) begin
            @(negedge clk);
            if (c == 0) begin
                req_rd = is_rd; req_wr = is_wr; cpu_addr = addr; cpu_wdata = wdata;
            end
            if (c == 1) begin
                cpu_addr = ~addr; cpu_wdata = ~wdata;
            end
            bus_i.bus_ack   = (c == waits + 1);
            bus_i.bus_rdata = (c == waits + 1) ? rdata : 8'h00;
            #1;
            if (stall) n_stall++;
            if (bus_i.bus_rd) begin
                n_rd++;
                if (first_cyc < 0) first_cyc = cyc;
            end
            if (bus_i.bus_wr) n_wr++;
            if (bus_err) n_err++;
            if ((bus_i.bus_rd || bus_i.bus_wr) &&
                (bus_i.bus_addr !== addr || bus_i.bus_wdata !== wdata)) held = 1'b0;
            if (c > 0 && !stall) begin
                ended = 1'b1; req_rd = 1'b0; req_wr = 1'b0; bus_i.bus_ack = 1'b0;
            end
        end
    endtask

    task automatic test_reset;
        @(negedge clk); @(negedge clk); #1;
        total++;
        if ({stall, bus_i.bus_rd, bus_i.bus_wr, bus_err} !== 4'b0000) begin
            bad++; $display("FAIL reset_ctrl: got %b want 0000", {stall, bus_i.bus_rd, bus_i.bus_wr, bus_err});
        end
        total++;
        if ({bus_i.bus_addr, bus_i.bus_wdata, cpu_rdata} !== 24'h0) begin
            bad++; $display("FAIL reset_data: got %h want 000000", {bus_i.bus_addr, bus_i.bus_wdata, cpu_rdata});
        end
        @(negedge clk); rst = 1'b1;
    endtask

    task automatic test_read_zero_wait;
        int ns, nr, nw, ne, fc; logic h, e;
        do_xfer(1'b1, 1'b0, 8'h3C, 8'h00, 0, 8'hA5, ns, nr, nw, ne, h, fc, e);
        total++; if (e !== 1'b1) begin bad++; $display("FAIL rd0_end: got %b want 1", e); end
        total++; if (ns != 2) begin bad++; $display("FAIL rd0_stall: got %0d want 2", ns); end
        total++; if (nr != 1 || nw != 0) begin bad++; $display("FAIL rd0_strobe: got rd=%0d wr=%0d want rd=1 wr=0", nr, nw); end
        total++; if (h !== 1'b1) begin bad++; $display("FAIL rd0_addr: got unstable want bus_addr=3c"); end
        total++; if (cpu_rdata !== 8'hA5) begin bad++; $display("FAIL rd0_data: got %h want a5", cpu_rdata); end
        // Request held in DONE must be ignored: next cycle is a quiet IDLE.
        @(negedge clk); #1;
        total++; if ({stall, bus_i.bus_rd} !== 2'b00) begin bad++; $display("FAIL rd0_idle: got %b want 00", {stall, bus_i.bus_rd}); end
    endtask

    task automatic test_write_waits;
        int ns, nr, nw, ne, fc; logic h, e;
        do_xfer(1'b0, 1'b1, 8'h10, 8'h5A, 3, 8'hCC, ns, nr, nw, ne, h, fc, e);
        total++; if (ns != 5) begin bad++; $display("FAIL wr3_stall: got %0d want 5", ns); end
        total++; if (nw != 4 || nr != 0) begin bad++; $display("FAIL wr3_strobe: got wr=%0d rd=%0d want wr=4 rd=0", nw, nr); end
        total++; if (h !== 1'b1) begin bad++; $display("FAIL wr3_hold: got unstable want addr=10 wdata=5a"); end
        total++; if (cpu_rdata !== 8'hA5) begin bad++; $display("FAIL wr3_rdata: got %h want a5", cpu_rdata); end
    endtask

    task automatic test_both_req;
        int ns, nr, nw, ne, fc; logic h, e;
        do_xfer(1'b1, 1'b1, 8'h20, 8'h33, 0, 8'h77, ns, nr, nw, ne, h, fc, e);
        total++; if (nw != 1 || nr != 0) begin bad++; $display("FAIL both_prio: got wr=%0d rd=%0d want wr=1 rd=0", nw, nr); end
        total++; if (cpu_rdata !== 8'hA5) begin bad++; $display("FAIL both_rdata: got %h want a5", cpu_rdata); end
    endtask

    task automatic test_ack_outside;
        int n_bad = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus_i.bus_ack = 1'b1; bus_i.bus_rdata = 8'h99;
            #1;
            if (cpu_rdata !== 8'hA5 || stall !== 1'b0 || bus_i.bus_rd !== 1'b0) n_bad++;
        end
        bus_i.bus_ack = 1'b0; bus_i.bus_rdata = 8'h00;
        total++; if (n_bad != 0) begin bad++; $display("FAIL ack_idle: got %0d disturbed cycles want 0", n_bad); end
    endtask

`ifdef MEM_BUS_TIMEOUT_EN
    task automatic test_timeout;
        int ns, nr, nw, ne, fc; logic h, e;
        do_xfer(1'b1, 1'b0, 8'h55, 8'h00, 1000, 8'h00, ns, nr, nw, ne, h, fc, e);
        total++; if (e !== 1'b1) begin bad++; $display("FAIL tmo_end: got %b want 1", e); end
        total++; if (ns != 16 || nr != 15) begin bad++; $display("FAIL tmo_len: got stall=%0d rd=%0d want 16 15", ns, nr); end
        total++; if (ne != 1) begin bad++; $display("FAIL tmo_err: got %0d want 1", ne); end
        total++; if (cpu_rdata !== 8'hFF) begin bad++; $display("FAIL tmo_data: got %h want ff", cpu_rdata); end
        @(negedge clk); #1;
        total++; if ({bus_err, stall} !== 2'b00) begin bad++; $display("FAIL tmo_after: got %b want 00", {bus_err, stall}); end
        do_xfer(1'b1, 1'b0, 8'h56, 8'h00, 14, 8'h3E, ns, nr, nw, ne, h, fc, e);
        total++; if (ne != 0 || ns != 16) begin bad++; $display("FAIL tmo_race: got err=%0d stall=%0d want 0 16", ne, ns); end
        total++; if (cpu_rdata !== 8'h3E) begin bad++; $display("FAIL tmo_race_data: got %h want 3e", cpu_rdata); end
        do_xfer(1'b0, 1'b1, 8'h57, 8'h11, 1000, 8'h00, ns, nr, nw, ne, h, fc, e);
        total++; if (ne != 1 || cpu_rdata !== 8'h3E) begin bad++; $display("FAIL tmo_wr: got err=%0d data=%h want 1 3e", ne, cpu_rdata); end
    endtask
`else
    task automatic test_long_wait;
        int ns, nr, nw, ne, fc; logic h, e;
        do_xfer(1'b1, 1'b0, 8'h55, 8'h00, 40, 8'hC3, ns, nr, nw, ne, h, fc, e);
        total++; if (ns != 42 || nr != 41) begin bad++; $display("FAIL long_len: got stall=%0d rd=%0d want 42 41", ns, nr); end
        total++; if (ne != 0) begin bad++; $display("FAIL long_err: got %0d want 0", ne); end
        total++; if (cpu_rdata !== 8'hC3) begin bad++; $display("FAIL long_data: got %h want c3", cpu_rdata); end
    endtask
`endif

    task automatic test_reset_mid;
        int ns, nr, nw, ne, fc; logic h, e;
        @(negedge clk);
        req_rd = 1'b1; cpu_addr = 8'h44; bus_i.bus_ack = 1'b0;
        @(negedge clk); #1;
        total++; if ({bus_i.bus_rd, stall} !== 2'b11) begin bad++; $display("FAIL rstm_pre: got %b want 11", {bus_i.bus_rd, stall}); end
        #1 rst = 1'b0;
        #1;
        total++; if ({bus_i.bus_rd, bus_i.bus_wr, stall, bus_err} !== 4'b0000) begin
            bad++; $display("FAIL rstm_ctrl: got %b want 0000", {bus_i.bus_rd, bus_i.bus_wr, stall, bus_err});
        end
        total++; if ({bus_i.bus_addr, bus_i.bus_wdata, cpu_rdata} !== 24'h0) begin
            bad++; $display("FAIL rstm_data: got %h want 000000", {bus_i.bus_addr, bus_i.bus_wdata, cpu_rdata});
        end
        req_rd = 1'b0;
        @(negedge clk); rst = 1'b1;
        do_xfer(1'b1, 1'b0, 8'h61, 8'h00, 1, 8'h2D, ns, nr, nw, ne, h, fc, e);
        total++; if (ns != 3 || cpu_rdata !== 8'h2D) begin bad++; $display("FAIL rstm_fresh: got stall=%0d data=%h want 3 2d", ns, cpu_rdata); end
    endtask

    task automatic test_back_to_back;
        int ns, nr, nw, ne, f1, f2; logic h, e;
        do_xfer(1'b1, 1'b0, 8'h01, 8'h00, 0, 8'hB1, ns, nr, nw, ne, h, f1, e);
        total++; if (cpu_rdata !== 8'hB1) begin bad++; $display("FAIL b2b_first: got %h want b1", cpu_rdata); end
        do_xfer(1'b1, 1'b0, 8'h02, 8'h00, 0, 8'hB2, ns, nr, nw, ne, h, f2, e);
        total++; if (cpu_rdata !== 8'hB2 || h !== 1'b1) begin bad++; $display("FAIL b2b_second: got %h want b2", cpu_rdata); end
        total++; if (f2 - f1 != 3) begin bad++; $display("FAIL b2b_spacing: got %0d want 3", f2 - f1); end
    endtask

    initial begin
        bus_i.bus_ack   = 1'b0;
        bus_i.bus_rdata = 8'h00;
        test_reset();
        test_read_zero_wait();
        test_write_waits();
        test_both_req();
        test_ack_outside();
`ifdef MEM_BUS_TIMEOUT_EN
        test_timeout();
`else
        test_long_wait();
`endif
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
